multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instruction bits [31:26], driven from the external IR.
- funct  in  6  instruction bits [5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete.
- ALUsrc  out  1  0 selects the register B operand; 1 selects the extended immediate.
- ALUctr  out  4  ALU operation code.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- PCSrc  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- IorD  out  1  memory address source: 0 = PC, 1 = ALU result.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write strobe.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- MemtoReg  out  1  write-back data: 1 = memory, 0 = ALU.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- state  out  3  current FSM state, for debug.

Function
REQ-003 The FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL transition to FETCH with all outputs 0.
REQ-004 ALUctr encodings SHALL be: ADD=0010, SUB=0110, AND=0000, OR=0001, XOR=0100, SLT=0111, SLL=1000, SRL=1001.
REQ-005 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, j 000010.
REQ-006 Supported R-type funct values SHALL be: add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010, sll 000000, srl 000010.
REQ-007 Outputs SHALL be decoded combinationally from state, the latched opcode/funct, Zero, and mem_ready; every output not asserted in a state SHALL be 0.
REQ-008 FETCH behaviour:
- MemRead=1 and IorD=0 every cycle.
- While mem_ready=0: hold in FETCH.
- On mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=00, next state DECODE.
REQ-009 DECODE SHALL latch opcode and funct into internal registers; these registers drive all decoding in EXEC, MEM and WB.
REQ-010 DECODE transitions:
- j: PCWrite=1, PCSrc=10, next state FETCH.
- Unsupported opcode, or R-type with unsupported funct: illegal=1 for this cycle, next state FETCH.
- Otherwise: next state EXEC.
REQ-011 EXEC by instruction:
- R-type: ALUsrc=0, ALUctr per funct.
- lw/sw and addi: ALUsrc=1, ALUctr=ADD.
- ori: ALUsrc=1, ALUctr=OR.
- beq: ALUsrc=0, ALUctr=SUB.
REQ-012 In EXEC for beq, PCWrite SHALL equal Zero and PCSrc SHALL be 01; the next state SHALL be FETCH regardless of Zero.
REQ-013 EXEC next state SHALL be MEM for lw/sw and WB for R-type, addi and ori.
REQ-014 MEM behaviour:
- IorD=1 every cycle.
- lw: MemRead=1; sw: MemWrite=1.
- Hold while mem_ready=0.
- On mem_ready=1: lw goes to WB, sw goes to FETCH.
REQ-015 WB SHALL assert RegWrite=1 for exactly one cycle, then go to FETCH.
- R-type: RegDst=1, MemtoReg=0.
- addi/ori: RegDst=0, MemtoReg=0.
- lw: RegDst=0, MemtoReg=1.
REQ-016 A memory stall SHALL have unbounded length; the strobes SHALL remain stable throughout the stall.
REQ-017 Changes on opcode/funct after DECODE SHALL have no effect until the next DECODE.
REQ-018 Instruction latency in cycles, excluding stalls, SHALL be: j 2, beq 3, R-type/addi/ori 4, sw 4, lw 5.

Reset
REQ-019 rst_n=0 at a rising edge SHALL set state to FETCH and clear the opcode/funct latches.
REQ-020 While rst_n=0, all outputs SHALL be forced to 0, including MemRead.
REQ-021 Reset SHALL take effect from any state, including mid-stall in MEM; the interrupted instruction SHALL produce no RegWrite or PCWrite afterwards.
REQ-022 In the first cycle after rst_n rises, the block SHALL be in FETCH with MemRead=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- add (op 000000, funct 100000), mem_ready=1 throughout -> states 0,1,2,4,0; ALUctr=0010 in EXEC; RegWrite=1 and RegDst=1 in WB.
- lw with mem_ready low for 3 MEM cycles -> MEM held 4 cycles with MemRead=1 and IorD=1; then WB with MemtoReg=1 and RegWrite=1.
- beq with Zero=1 -> EXEC shows PCWrite=1, PCSrc=01, ALUctr=0110; repeat with Zero=0 -> PCWrite=0 in EXEC.
- j -> DECODE shows PCWrite=1 and PCSrc=10; EXEC is never entered.
- opcode 111111, then R-type with funct 111111 -> illegal=1 for one DECODE cycle each; next state FETCH; no RegWrite.
- rst_n low for one cycle during a sw MEM stall -> next cycle state=0 with all outputs 0; MemWrite never reasserts for that sw.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Groups the signals between the multicycle controller and its datapath.
//   opcode/funct   : instruction fields from the external IR
//   Zero           : ALU zero flag
//   mem_ready      : memory access complete
//   ALUsrc, ALUctr : ALU operand select and operation
//   IRWrite,PCWrite: IR / PC load enables
//   PCSrc          : PC source select
//   IorD           : memory address source
//   MemRead/Write  : memory strobes
//   RegWrite,RegDst,MemtoReg : register file write controls
//   illegal        : unsupported instruction pulse
//   state          : current FSM state (debug)
// modport master is the controller side, slave the datapath side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic       ALUsrc;
    logic [3:0] ALUctr;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output ALUsrc, ALUctr, IRWrite, PCWrite, PCSrc, IorD,
               MemRead, MemWrite, RegWrite, RegDst, MemtoReg, illegal, state
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  ALUsrc, ALUctr, IRWrite, PCWrite, PCSrc, IorD,
               MemRead, MemWrite, RegWrite, RegDst, MemtoReg, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a five-state multicycle MIPS-style datapath
// (FETCH, DECODE, EXEC, MEM, WB).
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : multicycle_ctrl_if.master -- instruction fields, status flags in;
//           datapath control strobes, illegal pulse and debug state out.
// All control outputs are decoded combinationally from the state, the
// opcode/funct latched in DECODE, Zero and mem_ready, and are held at 0
// while rst_n is low.
// ---------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_ctrl_if.master        bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    state_t     state_q, state_d;
    logic [5:0] op_q, fn_q;

    logic       alusrc_c, irwrite_c, pcwrite_c, iord_c;
    logic       memread_c, memwrite_c, regwrite_c, regdst_c, memtoreg_c, illegal_c;
    logic [3:0] aluctr_c;
    logic [1:0] pcsrc_c;

    function automatic logic op_ok(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J: op_ok = 1'b1;
            default:                                           op_ok = 1'b0;
        endcase
    endfunction

    function automatic logic funct_ok(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b101010, 6'b000000, 6'b000010: funct_ok = 1'b1;
            default:                                    funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b100110: funct_alu = ALU_XOR;
            6'b101010: funct_alu = ALU_SLT;
            6'b000000: funct_alu = ALU_SLL;
            6'b000010: funct_alu = ALU_SRL;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    // State register and instruction-field latches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        alusrc_c   = 1'b0;
        aluctr_c   = 4'b0000;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        pcsrc_c    = 2'b00;
        iord_c     = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        illegal_c  = 1'b0;

        case (state_q)
            FETCH: begin
                memread_c = 1'b1;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = DECODE;
                end
            end

            // The latches load at the end of this cycle, so DECODE itself
            // looks at the live instruction fields.
            DECODE: begin
                if (bus.opcode == OP_J) begin
                    pcwrite_c = 1'b1;
                    pcsrc_c   = 2'b10;
                    state_d   = FETCH;
                end else if (!op_ok(bus.opcode) ||
                             (bus.opcode == OP_R && !funct_ok(bus.funct))) begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                case (op_q)
                    OP_R: begin
                        aluctr_c = funct_alu(fn_q);
                        state_d  = WB;
                    end
                    OP_LW, OP_SW: begin
                        alusrc_c = 1'b1;
                        aluctr_c = ALU_ADD;
                        state_d  = MEM;
                    end
                    OP_ADDI: begin
                        alusrc_c = 1'b1;
                        aluctr_c = ALU_ADD;
                        state_d  = WB;
                    end
                    OP_ORI: begin
                        alusrc_c = 1'b1;
                        aluctr_c = ALU_OR;
                        state_d  = WB;
                    end
                    OP_BEQ: begin
                        aluctr_c  = ALU_SUB;
                        pcwrite_c = bus.Zero;
                        pcsrc_c   = 2'b01;
                        state_d   = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end

            // Strobes depend only on the latched opcode, so they stay
            // stable for the whole stall.
            MEM: begin
                iord_c     = 1'b1;
                memread_c  = (op_q == OP_LW);
                memwrite_c = (op_q == OP_SW);
                if (bus.mem_ready)
                    state_d = (op_q == OP_LW) ? WB : FETCH;
            end

            WB: begin
                regwrite_c = 1'b1;
                regdst_c   = (op_q == OP_R);
                memtoreg_c = (op_q == OP_LW);
                state_d    = FETCH;
            end

            default: state_d = FETCH;
        endcase
    end

    // Everything is forced low while reset is held.
    assign bus.ALUsrc   = rst_n & alusrc_c;
    assign bus.ALUctr   = rst_n ? aluctr_c : 4'b0000;
    assign bus.IRWrite  = rst_n & irwrite_c;
    assign bus.PCWrite  = rst_n & pcwrite_c;
    assign bus.PCSrc    = rst_n ? pcsrc_c : 2'b00;
    assign bus.IorD     = rst_n & iord_c;
    assign bus.MemRead  = rst_n & memread_c;
    assign bus.MemWrite = rst_n & memwrite_c;
    assign bus.RegWrite = rst_n & regwrite_c;
    assign bus.RegDst   = rst_n & regdst_c;
    assign bus.MemtoReg = rst_n & memtoreg_c;
    assign bus.illegal  = rst_n & illegal_c;
    assign bus.state    = rst_n ? state_q : FETCH;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each scenario task builds a
// per-cycle stimulus table with the expected output vector, pushes the
// expectation to a scoreboard queue as the stimulus is applied, and pops
// and compares it on the falling edge of the same cycle.
// Output vector layout (19 bits):
//   [18:16] state [15] ALUsrc [14:11] ALUctr [10] IRWrite [9] PCWrite
//   [8:7] PCSrc [6] IorD [5] MemRead [4] MemWrite [3] RegWrite
//   [2] RegDst [1] MemtoReg [0] illegal
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk;
    logic rst_n;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [18:0] ALUSRC = 19'h1 << 15;
    localparam logic [18:0] IRW    = 19'h1 << 10;
    localparam logic [18:0] PCW    = 19'h1 << 9;
    localparam logic [18:0] IORD   = 19'h1 << 6;
    localparam logic [18:0] MR     = 19'h1 << 5;
    localparam logic [18:0] MW     = 19'h1 << 4;
    localparam logic [18:0] RW     = 19'h1 << 3;
    localparam logic [18:0] RD     = 19'h1 << 2;
    localparam logic [18:0] M2R    = 19'h1 << 1;
    localparam logic [18:0] ILL    = 19'h1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;

    typedef struct {
        logic        rstn;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [18:0] exp;
    } stim_t;

    int checks   = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    function automatic logic [18:0] ex(input logic [2:0] st, input logic [3:0] alu,
                                       input logic [1:0] pcs, input logic [18:0] f);
        ex = {st, 16'b0} | {4'b0, alu, 11'b0} | {10'b0, pcs, 7'b0} | f;
    endfunction

    function automatic stim_t mk(input logic rstn, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic mr, input logic [18:0] e);
        stim_t s;
        s.rstn = rstn; s.op = op; s.fn = fn; s.z = z; s.mr = mr; s.exp = e;
        return s;
    endfunction

    function automatic logic [18:0] obs();
        obs = {bus.state, bus.ALUsrc, bus.ALUctr, bus.IRWrite, bus.PCWrite, bus.PCSrc,
               bus.IorD, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.RegDst,
               bus.MemtoReg, bus.illegal};
    endfunction

    task automatic drive(input stim_t s);
        rst_n         = s.rstn;
        bus.opcode    = s.op;
        bus.funct     = s.fn;
        bus.Zero      = s.z;
        bus.mem_ready = s.mr;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(0, OP_LW, F_ADD, 1, 1, 19'h0));
        sq.push_back(mk(0, OP_SW, F_ADD, 1, 1, 19'h0));
        sq.push_back(mk(1, OP_R,  F_ADD, 0, 0, ex(0, 0, 0, MR)));
        sq.push_back(mk(1, OP_R,  F_ADD, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // add; the opcode/funct inputs are scrambled after DECODE and must be ignored
    task automatic test_add();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(1, OP_R,    F_ADD,     0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_R,    F_ADD,     0, 1, ex(1, 0, 0, 0)));
        sq.push_back(mk(1, 6'h3f,   6'h3f,     0, 1, ex(2, 4'b0010, 0, 0)));
        sq.push_back(mk(1, OP_LW,   6'b100010, 0, 1, ex(4, 0, 0, RW | RD)));
        sq.push_back(mk(1, OP_R,    F_ADD,     0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL add cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // All eight R-type functs back to back, checking ALUctr in EXEC
    task automatic test_rtype_functs();
        stim_t sq[$];
        logic [18:0] got, e;
        logic [5:0] fns [8];
        logic [3:0] alus[8];
        fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                 6'b100110, 6'b101010, 6'b000000, 6'b000010};
        alus = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                 4'b0100, 4'b0111, 4'b1000, 4'b1001};
        for (int k = 0; k < 8; k++) begin
            sq.push_back(mk(1, OP_R, fns[k], 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
            sq.push_back(mk(1, OP_R, fns[k], 0, 1, ex(1, 0, 0, 0)));
            sq.push_back(mk(1, OP_R, fns[k], 0, 1, ex(2, alus[k], 0, 0)));
            sq.push_back(mk(1, OP_R, fns[k], 0, 1, ex(4, 0, 0, RW | RD)));
        end
        sq.push_back(mk(1, OP_R, F_ADD, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL rtype_funct cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_stall();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(1, OP_LW, 0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_LW, 0, 0, 1, ex(1, 0, 0, 0)));
        sq.push_back(mk(1, OP_LW, 0, 0, 1, ex(2, 4'b0010, 0, ALUSRC)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(3, 0, 0, IORD | MR)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(3, 0, 0, IORD | MR)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(3, 0, 0, IORD | MR)));
        sq.push_back(mk(1, OP_SW, 0, 0, 1, ex(3, 0, 0, IORD | MR)));
        sq.push_back(mk(1, OP_SW, 0, 0, 1, ex(4, 0, 0, RW | M2R)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL lw_stall cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        stim_t sq[$];
        logic [18:0] got, e;
        for (int z = 1; z >= 0; z--) begin
            sq.push_back(mk(1, OP_BEQ, 0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
            sq.push_back(mk(1, OP_BEQ, 0, 0, 1, ex(1, 0, 0, 0)));
            sq.push_back(mk(1, OP_BEQ, 0, z[0], 1,
                            ex(2, 4'b0110, 2'b01, (z == 1) ? PCW : 19'h0)));
            sq.push_back(mk(1, OP_BEQ, 0, 0, 0, ex(0, 0, 0, MR)));
        end
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL beq cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jump();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(1, OP_J, 0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_J, 0, 0, 1, ex(1, 0, 2'b10, PCW)));
        sq.push_back(mk(1, OP_J, 0, 0, 0, ex(0, 0, 0, MR)));
        sq.push_back(mk(1, OP_J, 0, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL jump cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(1, 6'h3f, F_ADD, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, 6'h3f, F_ADD, 0, 1, ex(1, 0, 0, ILL)));
        sq.push_back(mk(1, OP_R,  6'h3f, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_R,  6'h3f, 0, 1, ex(1, 0, 0, ILL)));
        sq.push_back(mk(1, OP_R,  6'h3f, 0, 0, ex(0, 0, 0, MR)));
        sq.push_back(mk(1, OP_R,  6'h3f, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // sw, addi, ori back to back with no idle FETCH cycles between them
    task automatic test_back_to_back();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(1, OP_SW,   0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_SW,   0, 0, 1, ex(1, 0, 0, 0)));
        sq.push_back(mk(1, OP_SW,   0, 0, 1, ex(2, 4'b0010, 0, ALUSRC)));
        sq.push_back(mk(1, OP_SW,   0, 0, 1, ex(3, 0, 0, IORD | MW)));
        sq.push_back(mk(1, OP_ADDI, 0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_ADDI, 0, 0, 1, ex(1, 0, 0, 0)));
        sq.push_back(mk(1, OP_ADDI, 0, 0, 1, ex(2, 4'b0010, 0, ALUSRC)));
        sq.push_back(mk(1, OP_ADDI, 0, 0, 1, ex(4, 0, 0, RW)));
        sq.push_back(mk(1, OP_ORI,  0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_ORI,  0, 0, 1, ex(1, 0, 0, 0)));
        sq.push_back(mk(1, OP_ORI,  0, 0, 1, ex(2, 4'b0001, 0, ALUSRC)));
        sq.push_back(mk(1, OP_ORI,  0, 0, 1, ex(4, 0, 0, RW)));
        sq.push_back(mk(1, OP_ORI,  0, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Reset pulse during a sw MEM stall; MemWrite must never come back
    task automatic test_reset_mid_stall();
        stim_t sq[$];
        logic [18:0] got, e;
        sq.push_back(mk(1, OP_SW, 0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, OP_SW, 0, 0, 1, ex(1, 0, 0, 0)));
        sq.push_back(mk(1, OP_SW, 0, 0, 1, ex(2, 4'b0010, 0, ALUSRC)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(3, 0, 0, IORD | MW)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(3, 0, 0, IORD | MW)));
        sq.push_back(mk(0, OP_SW, 0, 0, 0, 19'h0));
        for (int k = 0; k < 4; k++)
            sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(0, 0, 0, MR)));
        sq.push_back(mk(1, OP_SW, 0, 0, 1, ex(0, 0, 0, MR | IRW | PCW)));
        sq.push_back(mk(1, 6'h3f, 0, 0, 1, ex(1, 0, 0, ILL)));
        sq.push_back(mk(1, OP_SW, 0, 0, 0, ex(0, 0, 0, MR)));
        foreach (sq[i]) begin
            drive(sq[i]);
            @(negedge clk);
            got = obs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_mid_stall cyc%0d got=%h exp=%h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_rtype_functs();
        test_lw_stall();
        test_beq();
        test_jump();
        test_illegal();
        test_back_to_back();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
